// File: rtl/main_fsm_ws.sv
// Multicycle control FSM with fixed-wait memory states and a retired-instruction counter.
// Define MEMREADY_EN to pace memory states with the MemReady handshake instead of WAIT_CYCLES.
module main_fsm_ws #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
`ifdef MEMREADY_EN
    input  logic             MemReady,
`endif
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             ALUOp,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [3:0]       State,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_mem_done;
    logic             w_retire;
    logic [CNT_W-1:0] r_count;

`ifdef MEMREADY_EN
    assign w_mem_done = MemReady;
`else
    logic [3:0] r_wait;
    logic       w_mem_state;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE);
    assign w_mem_done  = (r_wait == '0);

    // Counter sits at the reload value outside memory states, so every entry starts a full wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= 4'(WAIT_CYCLES);
        end else if (w_mem_state && !w_mem_done) begin
            r_wait <= r_wait - 4'd1;
        end else begin
            r_wait <= 4'(WAIT_CYCLES);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_next    = S_FETCH;
        w_retire  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        Illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = w_mem_done;
                NextPC    = w_mem_done;
                w_next    = w_mem_done ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: begin
                        w_next  = S_FETCH;
                        Illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = w_mem_done ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemW     = w_mem_done;
                w_retire = w_mem_done;
                w_next   = w_mem_done ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUOp  = 1'b1;
                w_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegW     = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign State      = r_state;
    assign InstrCount = r_count;

endmodule

// File: tb/tb_main_fsm_ws.sv
// Scoreboard bench for main_fsm_ws: three instances with different wait and counter widths,
// expected per-cycle records queued per instruction and compared on the falling edge.
module tb_main_fsm_ws;

    function automatic int unsigned wc_of(input int unsigned d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int unsigned cw_of(input int unsigned d);
        return (d == 1) ? 3 : 16;
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  st;
        logic [12:0] ctl;
        logic        ill;
        logic [15:0] cnt;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  op_a  [3];
    logic [5:0]  fn_a  [3];
    logic [3:0]  st_a  [3];
    logic [12:0] ctl_a [3];
    logic        ill_a [3];
    logic [15:0] cnt_a [3];

    rec_t        q[$];
    int unsigned mcnt[3];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic irw, adr, npc, rw, mw, br, aop, ill;
        logic [1:0] sa, sb, rs;
        logic [3:0] st;
        logic [cw_of(g)-1:0] cnt;

        main_fsm_ws #(.WAIT_CYCLES(wc_of(g)), .CNT_W(cw_of(g))) u_dut (
            .clk       (clk),
            .reset     (reset),
            .Op        (op_a[g]),
            .Funct     (fn_a[g]),
            .IRWrite   (irw),
            .AdrSrc    (adr),
            .NextPC    (npc),
            .RegW      (rw),
            .MemW      (mw),
            .Branch    (br),
            .ALUOp     (aop),
            .ALUSrcA   (sa),
            .ALUSrcB   (sb),
            .ResultSrc (rs),
            .State     (st),
            .Illegal   (ill),
            .InstrCount(cnt)
        );

        assign ctl_a[g] = {irw, npc, mw, adr, rw, br, aop, sa, sb, rs};
        assign st_a[g]  = st;
        assign ill_a[g] = ill;
        assign cnt_a[g] = 16'(cnt);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control word layout: {IRWrite, NextPC, MemW, AdrSrc, RegW, Branch, ALUOp, SrcA, SrcB, Result}
    function automatic logic [12:0] ctl_of(input logic [3:0] s, input logic stb);
        logic irw = 0, npc = 0, mw = 0, adr = 0, rw = 0, br = 0, aop = 0;
        logic [1:0] sa = 0, sb = 0, rs = 0;
        case (s)
            4'd0: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; irw = stb; npc = stb; end
            4'd1: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            4'd2: sb = 2'b01;
            4'd3: adr = 1;
            4'd4: begin rs = 2'b01; rw = 1; end
            4'd5: begin adr = 1; mw = stb; end
            4'd6: aop = 1;
            4'd7: begin sb = 2'b01; aop = 1; end
            4'd8: rw = 1;
            4'd9: begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = 1; end
            default: ;
        endcase
        return {irw, npc, mw, adr, rw, br, aop, sa, sb, rs};
    endfunction

    task automatic push_rec(input int unsigned d, input logic [3:0] s, input logic stb,
                            input logic ill, input logic [1:0] op, input logic [5:0] f);
        rec_t r;
        r.op = op; r.funct = f; r.st = s; r.ctl = ctl_of(s, stb); r.ill = ill;
        r.cnt = 16'(mcnt[d]);
        q.push_back(r);
    endtask

    task automatic push_mem(input int unsigned d, input logic [3:0] s,
                            input logic [1:0] op, input logic [5:0] f);
        for (int unsigned i = 0; i <= wc_of(d); i++)
            push_rec(d, s, i == wc_of(d), 1'b0, op, f);
    endtask

    task automatic push_instr(input int unsigned d, input logic [1:0] op, input logic [5:0] f);
        push_mem(d, 4'd0, op, f);
        push_rec(d, 4'd1, 1'b0, op == 2'b11, op, f);
        case (op)
            2'b01: begin
                push_rec(d, 4'd2, 1'b0, 1'b0, op, f);
                if (f[0]) begin
                    push_mem(d, 4'd3, op, f);
                    push_rec(d, 4'd4, 1'b0, 1'b0, op, f);
                end else begin
                    push_mem(d, 4'd5, op, f);
                end
            end
            2'b00: begin
                push_rec(d, f[5] ? 4'd7 : 4'd6, 1'b0, 1'b0, op, f);
                push_rec(d, 4'd8, 1'b0, 1'b0, op, f);
            end
            2'b10: push_rec(d, 4'd9, 1'b0, 1'b0, op, f);
            default: ;
        endcase
        if (op != 2'b11)
            mcnt[d] = (mcnt[d] + 1) & ((32'd1 << cw_of(d)) - 1);
    endtask

    task automatic drain(input int unsigned d, input int limit);
        rec_t r;
        int n = 0;
        while (q.size() > 0 && (limit < 0 || n < limit)) begin
            r = q.pop_front();
            n++;
            op_a[d] = r.op;
            fn_a[d] = r.funct;
            #1;
            check($sformatf("d%0d state", d), 32'(st_a[d]), 32'(r.st));
            check($sformatf("d%0d ctl", d), 32'(ctl_a[d]), 32'(r.ctl));
            check($sformatf("d%0d illegal", d), 32'(ill_a[d]), 32'(r.ill));
            check($sformatf("d%0d count", d), 32'(cnt_a[d]), 32'(r.cnt));
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int unsigned d = 0; d < 3; d++) begin
            check($sformatf("d%0d rst state", d), 32'(st_a[d]), 32'd0);
            check($sformatf("d%0d rst count", d), 32'(cnt_a[d]), 32'd0);
            check($sformatf("d%0d rst illegal", d), 32'(ill_a[d]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int unsigned d = 0; d < 3; d++) mcnt[d] = 0;
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int unsigned d = 0; d < 3; d++) begin
            op_a[d] = 2'b00;
            fn_a[d] = 6'd0;
        end

        // Zero-wait instance: every instruction class, including an illegal opcode.
        do_reset();
        push_instr(0, 2'b01, 6'b011001);
        push_instr(0, 2'b01, 6'b011000);
        push_instr(0, 2'b00, 6'b000100);
        push_instr(0, 2'b00, 6'b101000);
        push_instr(0, 2'b10, 6'b000000);
        push_instr(0, 2'b11, 6'b011001);
        push_instr(0, 2'b01, 6'b000001);
        drain(0, -1);

        // Two-cycle wait, 3-bit counter: nine retirements wrap the count.
        do_reset();
        push_instr(1, 2'b01, 6'b011000);
        push_instr(1, 2'b01, 6'b011001);
        for (int i = 0; i < 7; i++)
            push_instr(1, 2'(i % 3), (i % 2 == 0) ? 6'b100001 : 6'b000000);
        push_instr(1, 2'b11, 6'b000000);
        drain(1, -1);

        // Three-cycle wait: reset lands in the second MEMWRITE cycle.
        do_reset();
        push_instr(2, 2'b01, 6'b011001);
        drain(2, -1);
        push_instr(2, 2'b01, 6'b011000);
        drain(2, 7);
        #1;
        check("d2 pre-reset state", 32'(st_a[2]), 32'd5);
        check("d2 pre-reset count", 32'(cnt_a[2]), 32'd1);
        reset = 1'b1;
        #1;
        check("d2 async state", 32'(st_a[2]), 32'd0);
        check("d2 async count", 32'(cnt_a[2]), 32'd0);
        check("d2 async ctl", 32'(ctl_a[2]), 32'(ctl_of(4'd0, 1'b0)));
        @(negedge clk);
        check("d2 held state", 32'(st_a[2]), 32'd0);
        check("d2 held count", 32'(cnt_a[2]), 32'd0);
        reset = 1'b0;
        mcnt[2] = 0;
        q.delete();
        push_instr(2, 2'b01, 6'b011000);
        push_instr(2, 2'b10, 6'b000000);
        drain(2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
